// File: rtl/bta_cla_pkg.sv
// Shared constants and helpers for the eight-operand binary-tree adder.
//
// Contents:
//   N_OPS, OP_W, SUM_W, CLA_GRP : tree shape, default operand width,
//                                 result width and lookahead group size.
//   PIPE_DEPTH                  : clock cycles from input sampling to output.
//                                 It is 3 when BTA_CLA_8_PIPE_EN is defined
//                                 and 1 otherwise.
//   num_groups()                : number of 4-bit lookahead groups for a width.
//   la_carry()                  : lookahead carry into bit k of one group.
package bta_cla_pkg;

  localparam int N_OPS   = 8;
  localparam int OP_W    = 16;
  localparam int SUM_W   = OP_W + 3;
  localparam int CLA_GRP = 4;

`ifdef BTA_CLA_8_PIPE_EN
  localparam int PIPE_DEPTH = 3;
`else
  localparam int PIPE_DEPTH = 1;
`endif

  function automatic int num_groups(input int w);
    return (w + CLA_GRP - 1) / CLA_GRP;
  endfunction

  // Carry into position k (0..CLA_GRP) of a group, written as a flat
  // sum of products over g/p and the group carry-in. With a constant k,
  // this reduces to the classic two-level lookahead equations rather than
  // a ripple chain.
  function automatic logic la_carry(input logic [CLA_GRP-1:0] g,
                                    input logic [CLA_GRP-1:0] p,
                                    input logic               ci,
                                    input int                 k);
    logic r;
    logic t;
    r = 1'b0;
    for (int j = 0; j < k; j++) begin
      t = g[j];
      for (int l = j + 1; l < k; l++) begin
        t = t & p[l];
      end
      r = r | t;
    end
    t = ci;
    for (int l = 0; l < k; l++) begin
      t = t & p[l];
    end
    return r | t;
  endfunction

endpackage

// File: rtl/bta_cla_8_cla_adder.sv
// Carry-lookahead adder node for the binary adder tree.
//
// The adder is split into 4-bit groups. Inside each group, carries are
// computed with lookahead logic. Between groups, carries ripple.
// Widths that are not a multiple of 4 are handled by zero-padding the
// top group. The padded bits are zero, so they kill any carry, and the
// real carry-out is the carry into bit W.
//
// Parameter:
//   W    : operand width.
// Ports:
//   a, b : W-bit unsigned operands.
//   cin  : carry-in.
//   s    : W-bit sum.
//   cout : carry out of bit W-1.
module cla_adder
  import bta_cla_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int NG = num_groups(W);
  localparam int WP = NG * CLA_GRP;

  logic [WP-1:0] a_p;
  logic [WP-1:0] b_p;
  logic [WP-1:0] g;
  logic [WP-1:0] p;
  logic [W:0]    c;
  logic [NG-1:0] gc;   // carry into each group

  assign a_p = WP'(a);
  assign b_p = WP'(b);
  assign g   = a_p & b_p;
  assign p   = a_p ^ b_p;
  assign gc[0] = cin;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      for (gk = 0; gk < CLA_GRP; gk++) begin : g_bit
        if (gi * CLA_GRP + gk < W) begin : g_c
          assign c[gi*CLA_GRP+gk] = la_carry(g[gi*CLA_GRP +: CLA_GRP],
                                             p[gi*CLA_GRP +: CLA_GRP],
                                             gc[gi], gk);
        end
      end
      if (gi < NG - 1) begin : g_gc
        assign gc[gi+1] = la_carry(g[gi*CLA_GRP +: CLA_GRP],
                                   p[gi*CLA_GRP +: CLA_GRP],
                                   gc[gi], CLA_GRP);
      end
    end
  endgenerate

  // The carry into bit W comes from the top group, at an offset between
  // 1 and CLA_GRP within that group.
  assign c[W] = la_carry(g[(NG-1)*CLA_GRP +: CLA_GRP],
                         p[(NG-1)*CLA_GRP +: CLA_GRP],
                         gc[NG-1], W - (NG - 1) * CLA_GRP);

  assign s    = p[W-1:0] ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/bta_cla_8.sv
// Eight-operand binary-tree adder built from seven CLA nodes.
//
// Configuration macro: BTA_CLA_8_PIPE_EN.
//   When defined, registers sit after level 1, after level 2 and at the
//   output, for a latency of 3 cycles.
//   When undefined, the tree is purely combinational and feeds only the
//   output register, for a latency of 1 cycle.
//
// Parameter:
//   m : operand width (>= 4, multiple of 4).
// Ports:
//   clk                     : rising-edge clock.
//   rst                     : synchronous active-high reset; clears every register.
//   A, B, C, D, E, F, G, H  : m-bit unsigned operands.
//   C0                      : carry-in; only the A+B node adds it.
//   sum                     : registered (m+3)-bit total.
//   carry                   : registered carry-out of the root node.
module bta_cla_8
  import bta_cla_pkg::*;
#(
  parameter int m = OP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [m-1:0] A,
  input  logic [m-1:0] B,
  input  logic [m-1:0] C,
  input  logic [m-1:0] D,
  input  logic [m-1:0] E,
  input  logic [m-1:0] F,
  input  logic [m-1:0] G,
  input  logic [m-1:0] H,
  input  logic         C0,
  output logic [m+2:0] sum,
  output logic         carry
);

  localparam int L1_NODES = N_OPS / 2;
  localparam int L2_NODES = N_OPS / 4;

  logic [m-1:0] ops [N_OPS];

  assign ops[0] = A;
  assign ops[1] = B;
  assign ops[2] = C;
  assign ops[3] = D;
  assign ops[4] = E;
  assign ops[5] = F;
  assign ops[6] = G;
  assign ops[7] = H;

  // Node results are {cout, s}, so no bit of any partial sum is dropped.
  logic [m:0]   l1_d [L1_NODES];   // level-1 node results
  logic [m:0]   l1_s [L1_NODES];   // level-1 values seen by level 2
  logic [m+1:0] l2_d [L2_NODES];
  logic [m+1:0] l2_s [L2_NODES];
  logic [m+2:0] sum_d;
  logic         carry_d;
  logic [m+2:0] sum_q;
  logic         carry_q;

  genvar gi;
  generate
    for (gi = 0; gi < L1_NODES; gi++) begin : g_l1
      cla_adder #(.W(m)) u_node (
        .a    (ops[2*gi]),
        .b    (ops[2*gi+1]),
        .cin  ((gi == 0) ? C0 : 1'b0),
        .s    (l1_d[gi][m-1:0]),
        .cout (l1_d[gi][m])
      );
    end

    for (gi = 0; gi < L2_NODES; gi++) begin : g_l2
      cla_adder #(.W(m+1)) u_node (
        .a    (l1_s[2*gi]),
        .b    (l1_s[2*gi+1]),
        .cin  (1'b0),
        .s    (l2_d[gi][m:0]),
        .cout (l2_d[gi][m+1])
      );
    end
  endgenerate

  // The root is the (m+2)-bit node, zero-extended by one bit. Its m+3
  // result bits form the sum, and the adder's own carry-out is the flag
  // for anything beyond bit m+2. For legal inputs that flag is always 0.
  cla_adder #(.W(m+3)) u_root (
    .a    ({1'b0, l2_s[0]}),
    .b    ({1'b0, l2_s[1]}),
    .cin  (1'b0),
    .s    (sum_d),
    .cout (carry_d)
  );

`ifdef BTA_CLA_8_PIPE_EN
  logic [m:0]   l1_q [L1_NODES];
  logic [m+1:0] l2_q [L2_NODES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L1_NODES; i++) l1_q[i] <= '0;
      for (int i = 0; i < L2_NODES; i++) l2_q[i] <= '0;
    end else begin
      for (int i = 0; i < L1_NODES; i++) l1_q[i] <= l1_d[i];
      for (int i = 0; i < L2_NODES; i++) l2_q[i] <= l2_d[i];
    end
  end

  assign l1_s = l1_q;
  assign l2_s = l2_q;
`else
  assign l1_s = l1_d;
  assign l2_s = l2_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bta_cla_8.sv
// Self-checking bench for bta_cla_8 (m = 16).
//
// The reference model treats the DUT as a black box. Each rising edge, it
// records the plain integer sum of the eight operands plus C0, and whether
// reset was high on that edge. The expected output after edge j is the
// value recorded LAT-1 edges earlier. It is 0 instead if reset was high
// anywhere within that window.
module tb_bta_cla_8;

`ifdef BTA_CLA_8_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = '0, B = '0, C = '0, D = '0, E = '0, F = '0, G = '0, H = '0;
  logic        C0 = 1'b0;
  logic [18:0] sum;
  logic        carry;

  int total = 0;
  int bad   = 0;

  logic [15:0] op [8];
  logic        cin;
  logic [19:0] hist_val [$];
  bit          hist_rst [$];

  bta_cla_8 #(.m(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G),
    .H     (H),
    .C0    (C0),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Apply op/cin for one rising edge, then return 1 time unit after it.
  task automatic drive(input bit r);
    int acc;
    @(negedge clk);
    rst = r;
    A = op[0]; B = op[1]; C = op[2]; D = op[3];
    E = op[4]; F = op[5]; G = op[6]; H = op[7];
    C0 = cin;
    @(posedge clk);
    acc = int'(cin);
    for (int i = 0; i < 8; i++) acc += int'(op[i]);
    hist_val.push_back(20'(acc));
    hist_rst.push_back(r);
    #1;
  endtask

  function automatic logic [19:0] expected();
    int j = hist_val.size() - 1;
    for (int k = j - LAT + 1; k <= j; k++) begin
      if (k < 0) return 20'd0;
      if (hist_rst[k]) return 20'd0;
    end
    return hist_val[j-LAT+1];
  endfunction

  task automatic set_all(input logic [15:0] v, input logic c);
    for (int i = 0; i < 8; i++) op[i] = v;
    cin = c;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 8; i++) op[i] = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rand_ops();
      drive(1'b1);
      total++;
      if ({carry, sum} !== 20'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got sum=%h carry=%b want sum=0 carry=0", s, sum, carry);
      end
    end
    set_all(16'h0000, 1'b0);
    for (int s = 0; s < LAT + 1; s++) begin
      drive(1'b0);
      total++;
      if ({carry, sum} !== 20'd0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got sum=%h carry=%b want 0", s, sum, carry);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v1 [8];
    logic [15:0] v2 [8];
    logic [19:0] e;
    v1 = '{16'h5E3A, 16'hF0AE, 16'h5ACA, 16'h6B3E, 16'h593A, 16'h480E, 16'h39DA, 16'h5CBE};
    v2 = '{16'h730F, 16'h04BF, 16'h697B, 16'h0818, 16'hF5C7, 16'h5846, 16'h1239, 16'h53AF};
    for (int s = 0; s < LAT + 2; s++) begin
      if (s == 0)      op = v1;
      else if (s == 1) op = v2;
      else             set_all(16'h0000, 1'b0);
      cin = 1'b0;
      drive(1'b0);
      e = expected();
      total++;
      if ({carry, sum} !== e) begin
        bad++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", s, {carry, sum}, e);
      end
      if (s == LAT - 1) begin
        total++;
        if ({carry, sum} !== {1'b0, 19'h34CD0}) begin
          bad++;
          $display("FAIL vector1 got sum=%h carry=%b want sum=34cd0 carry=0", sum, carry);
        end
      end
      if (s == LAT) begin
        total++;
        if ({carry, sum} !== {1'b0, 19'h29D56}) begin
          bad++;
          $display("FAIL vector2 got sum=%h carry=%b want sum=29d56 carry=0", sum, carry);
        end
      end
    end
  endtask

  // Drive one vector, follow with zeros, and check the constant result.
  task automatic test_max();
    for (int s = 0; s < LAT; s++) begin
      if (s == 0) set_all(16'hFFFF, 1'b1);
      else        set_all(16'h0000, 1'b0);
      drive(1'b0);
    end
    total++;
    if ({carry, sum} !== {1'b0, 19'h7FFF9}) begin
      bad++;
      $display("FAIL max got sum=%h carry=%b want sum=7fff9 carry=0", sum, carry);
    end
  endtask

  task automatic test_carry_in();
    for (int s = 0; s < LAT + 1; s++) begin
      set_all(16'h0000, 1'b0);
      if (s == 0) cin = 1'b1;
      if (s == 1) begin op[5] = 16'hFFFF; cin = 1'b1; end
      drive(1'b0);
      if (s == LAT - 1) begin
        total++;
        if ({carry, sum} !== 20'h00001) begin
          bad++;
          $display("FAIL cin_only got sum=%h carry=%b want sum=00001", sum, carry);
        end
      end
      if (s == LAT) begin
        total++;
        if ({carry, sum} !== 20'h10000) begin
          bad++;
          $display("FAIL cin_ffff got sum=%h carry=%b want sum=10000", sum, carry);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] e;
    for (int s = 0; s < 40; s++) begin
      rand_ops();
      drive(s == 20);
      e = expected();
      total++;
      if ({carry, sum} !== e) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%h want=%h", s, {carry, sum}, e);
      end
      if (s >= 20 && s < 20 + LAT) begin
        total++;
        if ({carry, sum} !== 20'd0) begin
          bad++;
          $display("FAIL flush cyc=%0d got=%h want=0", s, {carry, sum});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_max();
    test_carry_in();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
